// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: FSM encodings, default timeout and one-hot decode shared by the bus arbiter
package bus_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_e;
    localparam int TIMEOUT_DEF = 16;
    function automatic int oh2idx(input logic [3:0] oh);
        oh2idx = 0;
        for (int i = 0; i < 4; i++)
            if (oh[i]) oh2idx = i;
    endfunction
endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: round-robin winner after ptr, or fixed priority (master 0 first) under ARB_FIXED_PRIO_EN
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);
`ifdef ARB_FIXED_PRIO_EN
    logic [IW-1:0] unused_ptr;
    assign unused_ptr = ptr;
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) idx = IW'(i);
    end
`else
    always_comb begin
        valid = |req;
        idx   = '0;
        // scanning downward lets the candidate nearest ptr+1 overwrite the rest
        for (int k = N; k >= 1; k--)
            if (req[IW'((int'(ptr) + k) % N)]) idx = IW'((int'(ptr) + k) % N);
    end
`endif
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: N-master single-slave bus arbiter with lock and timeout; ARB_FIXED_PRIO_EN selects fixed priority
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_MASTER = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_MASTER-1:0]        m_req,
    input  logic [N_MASTER-1:0]        m_we,
    input  logic [N_MASTER-1:0]        m_lock,
    input  logic [N_MASTER*ADDR_W-1:0] m_addr,
    input  logic [N_MASTER*DATA_W-1:0] m_wdata,
    output logic [N_MASTER-1:0]        m_gnt,
    output logic [N_MASTER-1:0]        m_ack,
    output logic [N_MASTER-1:0]        m_err,
    output logic [DATA_W-1:0]          m_rdata,
    output logic                       s_req,
    output logic                       s_we,
    output logic [ADDR_W-1:0]          s_addr,
    output logic [DATA_W-1:0]          s_wdata,
    input  logic                       s_ack,
    input  logic [DATA_W-1:0]          s_rdata
);
    localparam int IW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
    localparam int CW = $clog2(TIMEOUT);

    state_e              state_q, state_d;
    logic [N_MASTER-1:0] gnt_q, gnt_d, ack_q, ack_d, err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d, swdata_q, swdata_d;
    logic [ADDR_W-1:0]   saddr_q, saddr_d;
    logic                sreq_q, sreq_d, swe_q, swe_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       ptr_q, ptr_d, pick_idx, g, sel;
    logic                pick_valid, issue;

    rr_pick #(.N(N_MASTER), .IW(IW)) u_pick (
        .req   (m_req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        g        = IW'(oh2idx(4'(gnt_q)));
        sel      = (state_q == IDLE) ? pick_idx : g;
        issue    = (state_q == IDLE) ? pick_valid : (state_q == HOLD) && m_req[g];
        state_d  = state_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        err_d    = '0;
        rdata_d  = rdata_q;
        sreq_d   = sreq_q;
        swe_d    = swe_q;
        saddr_d  = saddr_q;
        swdata_d = swdata_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        if (issue) begin
            gnt_d    = N_MASTER'(1) << sel;
            ptr_d    = sel;
            sreq_d   = 1'b1;
            swe_d    = m_we[sel];
            saddr_d  = m_addr[sel*ADDR_W +: ADDR_W];
            swdata_d = m_wdata[sel*DATA_W +: DATA_W];
            cnt_d    = '0;
            state_d  = BUSY;
        end else if (state_q == BUSY) begin
            if (s_ack) begin
                sreq_d  = 1'b0;
                ack_d   = gnt_q;
                rdata_d = s_rdata;
                state_d = m_lock[g] ? HOLD : IDLE;
                gnt_d   = m_lock[g] ? gnt_q : '0;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                sreq_d  = 1'b0;
                err_d   = gnt_q;
                gnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (state_q == HOLD && !m_lock[g]) begin
            gnt_d   = '0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            ack_q    <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
            sreq_q   <= 1'b0;
            swe_q    <= 1'b0;
            saddr_q  <= '0;
            swdata_q <= '0;
            cnt_q    <= '0;
            ptr_q    <= IW'(N_MASTER - 1);
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            sreq_q   <= sreq_d;
            swe_q    <= swe_d;
            saddr_q  <= saddr_d;
            swdata_q <= swdata_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
        end
    end

    assign m_gnt   = gnt_q;
    assign m_ack   = ack_q;
    assign m_err   = err_q;
    assign m_rdata = rdata_q;
    assign s_req   = sreq_q;
    assign s_we    = swe_q;
    assign s_addr  = saddr_q;
    assign s_wdata = swdata_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of arbitration, lock bursts, timeout and reset for bus_arbiter
module tb_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  m_req, m_we, m_lock, m_gnt, m_ack, m_err;
    logic [63:0] m_addr, m_wdata;
    logic [31:0] m_rdata, s_addr, s_wdata, s_rdata;
    logic        s_req, s_we, s_ack;
    int          n_tests = 0;
    int          n_fail = 0;

    bus_arbiter #(.N_MASTER(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we), .m_lock(m_lock),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_gnt(m_gnt), .m_ack(m_ack), .m_err(m_err),
        .m_rdata(m_rdata), .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        m_req = 0; m_we = 0; m_lock = 0; m_addr = 0; m_wdata = 0; s_ack = 0; s_rdata = 0;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        reset = 1'b0;
        m_req = 2'b11;
        step();
        n_tests++; if (m_gnt !== 2'b00) begin n_fail++; $display("FAIL rst_gnt: got %b want 00", m_gnt); end
        n_tests++; if ({m_ack, m_err} !== 4'b0) begin n_fail++; $display("FAIL rst_ack_err: got %b want 0000", {m_ack, m_err}); end
        n_tests++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL rst_sreq: got %b want 0", s_req); end
        n_tests++; if (s_addr !== 32'h0) begin n_fail++; $display("FAIL rst_saddr: got %h want 0", s_addr); end
        n_tests++; if (m_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", m_rdata); end
        m_req = 2'b00;
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_read;
        m_addr[31:0] = 32'h7F00;
        m_req = 2'b01;
        step();
        n_tests++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL rd_gnt: got %b want 01", m_gnt); end
        n_tests++; if (s_req !== 1'b1 || s_we !== 1'b0) begin n_fail++; $display("FAIL rd_sreq_we: got %b%b want 10", s_req, s_we); end
        n_tests++; if (s_addr !== 32'h7F00) begin n_fail++; $display("FAIL rd_saddr: got %h want 00007f00", s_addr); end
        s_ack = 1'b1;
        s_rdata = 32'hDEADBEEF;
        step();
        n_tests++; if (m_ack !== 2'b01) begin n_fail++; $display("FAIL rd_ack: got %b want 01", m_ack); end
        n_tests++; if (m_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata: got %h want deadbeef", m_rdata); end
        n_tests++; if (s_req !== 1'b0 || m_gnt !== 2'b00) begin n_fail++; $display("FAIL rd_release: sreq %b gnt %b want 0 00", s_req, m_gnt); end
        m_req = 2'b00;
        s_ack = 1'b0;
        s_rdata = 32'h0;
        step();
        n_tests++; if (m_ack !== 2'b00) begin n_fail++; $display("FAIL rd_ack_pulse: got %b want 00", m_ack); end
        n_tests++; if (m_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata_hold: got %h want deadbeef", m_rdata); end
    endtask

    task automatic test_round_robin;
        logic [1:0]  exp;
        logic [31:0] exp_addr;
        do_reset();
        m_addr = {32'h1111_0000, 32'h0000_1111};
        m_req = 2'b11;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
            exp = 2'b01;
`else
            exp = (i % 2 == 1) ? 2'b10 : 2'b01;
`endif
            exp_addr = (exp == 2'b01) ? 32'h0000_1111 : 32'h1111_0000;
            step();
            n_tests++; if (m_gnt !== exp) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, m_gnt, exp); end
            n_tests++; if (s_addr !== exp_addr) begin n_fail++; $display("FAIL rr_saddr[%0d]: got %h want %h", i, s_addr, exp_addr); end
            s_ack = 1'b1;
            step();
            n_tests++; if (m_ack !== exp) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b want %b", i, m_ack, exp); end
            s_ack = 1'b0;
        end
        m_req = 2'b00;
        step();
    endtask

    task automatic test_lock_burst;
        logic [31:0] exp_addr;
        do_reset();
        m_addr = {32'h7F10, 32'h7F00};
        m_wdata = {32'hA0, 32'h0};
        m_we = 2'b10;
        m_lock = 2'b10;
        m_req = 2'b10;
        step();
        n_tests++; if (m_gnt !== 2'b10 || s_we !== 1'b1) begin n_fail++; $display("FAIL lk_first: gnt %b we %b want 10 1", m_gnt, s_we); end
        n_tests++; if (s_addr !== 32'h7F10 || s_wdata !== 32'hA0) begin n_fail++; $display("FAIL lk_first_bus: addr %h data %h want 7f10 a0", s_addr, s_wdata); end
        m_req = 2'b11;
        for (int b = 0; b < 3; b++) begin
            if (b == 2) m_lock = 2'b00;
            s_ack = 1'b1;
            step();
            n_tests++; if (m_ack !== 2'b10) begin n_fail++; $display("FAIL lk_ack[%0d]: got %b want 10", b, m_ack); end
            n_tests++; if (m_gnt !== ((b < 2) ? 2'b10 : 2'b00)) begin n_fail++; $display("FAIL lk_hold_gnt[%0d]: got %b", b, m_gnt); end
            s_ack = 1'b0;
            if (b < 2) begin
                exp_addr = 32'h7F10 + 32'(4 * (b + 1));
                m_addr[63:32] = exp_addr;
                m_wdata[63:32] = 32'hA1 + 32'(b);
                step();
                n_tests++; if (m_gnt !== 2'b10 || s_addr !== exp_addr) begin n_fail++; $display("FAIL lk_next[%0d]: gnt %b addr %h want 10 %h", b, m_gnt, s_addr, exp_addr); end
                n_tests++; if (s_wdata !== 32'hA1 + 32'(b)) begin n_fail++; $display("FAIL lk_wdata[%0d]: got %h", b, s_wdata); end
            end
        end
        m_req = 2'b01;
        step();
        n_tests++; if (m_gnt !== 2'b01 || s_addr !== 32'h7F00) begin n_fail++; $display("FAIL lk_m0_after: gnt %b addr %h want 01 7f00", m_gnt, s_addr); end
        s_ack = 1'b1;
        step();
        n_tests++; if (m_ack !== 2'b01) begin n_fail++; $display("FAIL lk_m0_ack: got %b want 01", m_ack); end
        s_ack = 1'b0;
        m_req = 2'b00;
        m_we = 2'b00;
        step();
    endtask

    task automatic test_timeout;
        logic held;
        held = 1'b1;
        m_addr[63:32] = 32'h7F20;
        m_req = 2'b10;
        step();
        n_tests++; if (s_req !== 1'b1 || m_gnt !== 2'b10) begin n_fail++; $display("FAIL to_start: sreq %b gnt %b want 1 10", s_req, m_gnt); end
        for (int i = 1; i < 16; i++) begin
            step();
            if (s_req !== 1'b1 || m_err !== 2'b00) held = 1'b0;
        end
        n_tests++; if (held !== 1'b1) begin n_fail++; $display("FAIL to_hold: sreq dropped or err early, got %b want 1", held); end
        step();
        n_tests++; if (s_req !== 1'b0 || m_err !== 2'b10 || m_gnt !== 2'b00) begin n_fail++; $display("FAIL to_abort: sreq %b err %b gnt %b want 0 10 00", s_req, m_err, m_gnt); end
        n_tests++; if (m_ack !== 2'b00) begin n_fail++; $display("FAIL to_no_ack: got %b want 00", m_ack); end
        m_req = 2'b00;
        step();
        n_tests++; if (m_err !== 2'b00) begin n_fail++; $display("FAIL to_err_pulse: got %b want 00", m_err); end
        m_req = 2'b10;
        step();
        n_tests++; if (m_gnt !== 2'b10 || s_req !== 1'b1) begin n_fail++; $display("FAIL to_next_gnt: gnt %b sreq %b want 10 1", m_gnt, s_req); end
        s_ack = 1'b1;
        step();
        n_tests++; if (m_ack !== 2'b10 || m_err !== 2'b00) begin n_fail++; $display("FAIL to_next_ack: ack %b err %b want 10 00", m_ack, m_err); end
        s_ack = 1'b0;
        m_req = 2'b00;
        step();
    endtask

    task automatic test_ack_timeout_coincide;
        m_req = 2'b01;
        step();
        for (int i = 1; i < 16; i++) step();
        s_ack = 1'b1;
        s_rdata = 32'hCAFE_F00D;
        step();
        n_tests++; if (m_ack !== 2'b01 || m_err !== 2'b00) begin n_fail++; $display("FAIL co_ack_wins: ack %b err %b want 01 00", m_ack, m_err); end
        n_tests++; if (m_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL co_rdata: got %h want cafef00d", m_rdata); end
        s_ack = 1'b0;
        m_req = 2'b00;
        step();
        n_tests++; if (m_err !== 2'b00 || m_ack !== 2'b00) begin n_fail++; $display("FAIL co_quiet: ack %b err %b want 00 00", m_ack, m_err); end
    endtask

    task automatic test_reset_mid_busy;
        m_req = 2'b01;
        step();
        step();
        step();
        reset = 1'b0;
        step();
        n_tests++; if (m_gnt !== 2'b00 || s_req !== 1'b0) begin n_fail++; $display("FAIL mr_clear: gnt %b sreq %b want 00 0", m_gnt, s_req); end
        n_tests++; if ({m_ack, m_err} !== 4'b0) begin n_fail++; $display("FAIL mr_silent: got %b want 0000", {m_ack, m_err}); end
        m_req = 2'b00;
        reset = 1'b1;
        step();
        n_tests++; if ({m_ack, m_err} !== 4'b0) begin n_fail++; $display("FAIL mr_after: got %b want 0000", {m_ack, m_err}); end
        m_req = 2'b11;
        step();
        n_tests++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL mr_first_win: got %b want 01", m_gnt); end
        s_ack = 1'b1;
        step();
        n_tests++; if (m_ack !== 2'b01) begin n_fail++; $display("FAIL mr_ack: got %b want 01", m_ack); end
        s_ack = 1'b0;
        m_req = 2'b00;
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_burst();
        test_timeout();
        test_ack_timeout_coincide();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
